// File: rtl/wb_gpio_scanner_pkg.sv
// Shared register map and FSM encoding for the GPIO scanning initiator.
package wb_gpio_scanner_pkg;

  // Byte offsets of the GPIO responder registers
  localparam logic [31:0] GPIO_DATA_OFS = 32'h0;
  localparam logic [31:0] GPIO_OUT_OFS  = 32'h4;
  localparam logic [31:0] GPIO_DIR_OFS  = 32'h8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RD   = 3'd4,
    ST_CMP  = 3'd5
  } state_t;

endpackage

// File: rtl/gpio_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle, and pops on an empty FIFO are ignored.
module gpio_evt_fifo #(
  parameter int W  = 24,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(2**AW));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at 2^AW; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_gpio_scanner.sv
// Wishbone initiator that configures a GPIO responder once per enable, then
// polls its data register and logs every change with a timestamp.
module wb_gpio_scanner
  import wb_gpio_scanner_pkg::*;
#(
  parameter int          GPIO_W   = 8,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter logic [31:0] DIR_INIT = 32'h0,
  parameter int          TS_W     = 16,
  parameter int          FIFO_AW  = 3,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              en,
  input  logic [15:0]       period,
  input  logic              evt_pop,
  output logic              evt_valid,
  output logic [GPIO_W-1:0] evt_data,
  output logic [TS_W-1:0]   evt_ts,
  output logic              evt_ovf,
  input  logic              evt_ovf_clr,
  output logic              bus_err,
  output logic              irq
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_d;
  logic              en_q, first_pend;
  logic [15:0]       per_cnt, period_eff;
  logic [TO_W-1:0]   to_cnt;
  logic [TS_W-1:0]   ts, samp_ts;
  logic [GPIO_W-1:0] samp, last;
  logic              in_txn, ack_ok, to_hit, push;
  logic              fifo_full, fifo_empty;
  logic              cyc_d, we_d;
  logic [31:0]       adr_d, dat_d;
  logic              unused_dat;

  assign unused_dat = ^wb_dat_i;
  assign period_eff = (period == 16'd0) ? 16'd1 : period;
  assign in_txn     = (state == ST_CFG) || (state == ST_RD);
  assign ack_ok     = in_txn && wb_ack_i;
  assign to_hit     = in_txn && !wb_ack_i && (to_cnt == TO_W'(TIMEOUT - 1));
  assign push       = (state == ST_CMP) && !first_pend && (samp != last);

  // Next state plus next bus outputs; outputs are registered from state_d
  always_comb begin
    state_d = state;
    cyc_d   = 1'b0;
    we_d    = 1'b0;
    adr_d   = '0;
    dat_d   = '0;
    unique case (state)
      ST_IDLE: if (en && !en_q) state_d = ST_CFG;
      ST_CFG, ST_RD: begin
        if (ack_ok || to_hit) begin
          if (!en)                           state_d = ST_IDLE;
          else if (ack_ok && state == ST_RD) state_d = ST_CMP;
          else                               state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = en ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!en)                   state_d = ST_IDLE;
        else if (per_cnt <= 16'd1) state_d = ST_RD;
      end
      ST_CMP:  state_d = ST_GAP;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_CFG) begin
      cyc_d = 1'b1;
      we_d  = 1'b1;
      adr_d = BASE_ADR + GPIO_DIR_OFS;
      dat_d[GPIO_W-1:0] = DIR_INIT[GPIO_W-1:0];
    end else if (state_d == ST_RD) begin
      cyc_d = 1'b1;
      adr_d = BASE_ADR + GPIO_DATA_OFS;
    end
  end

  // State register and registered Wishbone outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= cyc_d;
      wb_we_o  <= we_d;
      wb_adr_o <= adr_d;
      wb_dat_o <= dat_d;
    end
  end

  // Timestamp, poll period, ack timeout and enable-edge bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts      <= '0;
      per_cnt <= '0;
      to_cnt  <= '0;
      en_q    <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      ts      <= ts + TS_W'(1);
      en_q    <= en;
      bus_err <= to_hit;
      if (state == ST_GAP)       per_cnt <= period_eff;
      else if (state == ST_WAIT) per_cnt <= per_cnt - 16'd1;
      if (in_txn && state_d == state) to_cnt <= to_cnt + TO_W'(1);
      else                            to_cnt <= '0;
    end
  end

  // Sample capture, change detection and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_pend <= 1'b0;
      samp       <= '0;
      samp_ts    <= '0;
      last       <= '0;
      evt_ovf    <= 1'b0;
    end else begin
      if (state == ST_IDLE && state_d == ST_CFG) first_pend <= 1'b1;
      if (state == ST_RD && wb_ack_i) begin
        samp    <= wb_dat_i[GPIO_W-1:0];
        samp_ts <= ts;
      end
      if (state == ST_CMP) begin
        first_pend <= 1'b0;
        if (first_pend || samp != last) last <= samp;
      end
      if (push && fifo_full && !evt_pop) evt_ovf <= 1'b1;
      else if (evt_ovf_clr)              evt_ovf <= 1'b0;
    end
  end

  gpio_evt_fifo #(
    .W  (GPIO_W + TS_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (evt_pop),
    .din   ({samp, samp_ts}),
    .dout  ({evt_data, evt_ts}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign irq       = evt_valid | evt_ovf;

endmodule

// File: tb/tb_wb_gpio_scanner.sv
// Directed bench: GPIO responder model, event scoreboard, immediate assertions.
module tb_wb_gpio_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic        en = 1'b0;
  logic [15:0] period = 16'd10;
  logic        evt_pop = 1'b0, evt_ovf_clr = 1'b0;
  logic        evt_valid, evt_ovf, bus_err, irq;
  logic [7:0]  evt_data;
  logic [15:0] evt_ts;

  wb_gpio_scanner dut (
    .clk(clk), .rst(rst), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .en(en), .period(period), .evt_pop(evt_pop), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ts(evt_ts), .evt_ovf(evt_ovf), .evt_ovf_clr(evt_ovf_clr), .bus_err(bus_err), .irq(irq)
  );

  always #5 clk = ~clk;

  // Responder model: registered ack after ack_delay extra cycles; reads may be ignored
  logic [7:0] pins = 8'h00;
  int         ack_delay = 0;
  bit         no_ack = 1'b0;
  int         rsp_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_i <= 1'b0; wb_dat_i <= '0; rsp_cnt <= 0;
    end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (!wb_we_o && no_ack) wb_ack_i <= 1'b0;
      else if (rsp_cnt >= ack_delay) begin
        wb_ack_i <= 1'b1; wb_dat_i <= {24'h0, pins}; rsp_cnt <= 0;
      end else rsp_cnt <= rsp_cnt + 1;
    end else begin
      wb_ack_i <= 1'b0; rsp_cnt <= 0;
    end
  end

  // Reference timestamp: free-running from reset release
  logic [15:0] tb_ts;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  typedef struct { logic [7:0] data; logic [15:0] ts; } evt_t;
  evt_t q[$];

  int          n_vec = 0, n_err = 0;
  int          n_wr = 0, n_rd = 0, stb_rises = 0, low_run = 0, last_gap = 0;
  int          cyc_run = 0, last_cyc_len = 0, n_berr = 0;
  logic [31:0] wr_adr = '0, wr_dat = '0, rd_adr = '0;
  logic        m_first = 1'b1, exp_ovf = 1'b0, stb_prev = 1'b0, cyc_prev = 1'b0;
  logic [7:0]  m_last = '0;

  // Bus monitor and scoreboard producer
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_ovf <= 1'b0; m_first <= 1'b1;
    end else begin
      if (evt_ovf_clr) exp_ovf <= 1'b0;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        if (wb_we_o) begin
          n_wr <= n_wr + 1; wr_adr <= wb_adr_o; wr_dat <= wb_dat_o; m_first <= 1'b1;
        end else begin
          n_rd <= n_rd + 1; rd_adr <= wb_adr_o;
          if (en) begin
            if (m_first) begin
              m_first <= 1'b0; m_last <= wb_dat_i[7:0];
            end else if (wb_dat_i[7:0] != m_last) begin
              m_last <= wb_dat_i[7:0];
              if (q.size() < 8) q.push_back('{wb_dat_i[7:0], tb_ts});
              else exp_ovf <= 1'b1;
            end
          end
        end
      end
    end
    stb_prev <= wb_stb_o;
    cyc_prev <= wb_cyc_o;
    if (wb_stb_o && !stb_prev) begin
      stb_rises <= stb_rises + 1; last_gap <= low_run;
    end
    low_run <= wb_stb_o ? 0 : low_run + 1;
    if (wb_cyc_o) cyc_run <= cyc_run + 1;
    else begin
      if (cyc_prev) last_cyc_len <= cyc_run;
      cyc_run <= 0;
    end
    if (bus_err) n_berr <= n_berr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input int target, input int limit);
    int i = 0;
    while (n_rd < target && i < limit) begin @(negedge clk); i++; end
    chk("read_within_bound", 32'(n_rd >= target), 32'd1);
  endtask

  task automatic wait_rd_strobe(input int limit);
    int i = 0;
    while (!(wb_cyc_o && !wb_we_o) && i < limit) begin @(negedge clk); i++; end
    chk("rd_strobe_within_bound", 32'(wb_cyc_o && !wb_we_o), 32'd1);
  endtask

  task automatic set_pins(input logic [7:0] v);
    pins = v;
    wait_rd(n_rd + 2, 60);
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    evt_t e;
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_data"}, 32'(evt_data), 32'(e.data));
      chk({tag, "_ts"}, 32'(evt_ts), 32'(e.ts));
    end else chk({tag, "_model_depth"}, 32'(q.size()), 32'd1);
    evt_pop = 1'b1;
    @(negedge clk);
    evt_pop = 1'b0;
  endtask

  initial begin
    int b0, r0, s0, i;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 0);  chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_we", 32'(wb_we_o), 0);    chk("rst_adr", wb_adr_o, 0);
    chk("rst_valid", 32'(evt_valid), 0); chk("rst_ovf", 32'(evt_ovf), 0);
    chk("rst_berr", 32'(bus_err), 0);  chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_no_strobe", 32'(stb_rises), 0);

    // 1. enable: one config write, then polling with a 12-cycle idle gap
    en = 1'b1;
    wait_rd(3, 200);
    chk("cfg_writes", 32'(n_wr), 1);
    chk("cfg_adr", wr_adr, 32'h8);
    chk("cfg_dat", wr_dat, 32'h0);
    chk("rd_adr", rd_adr, 32'h0);
    chk("poll_gap", 32'(last_gap), 32'd12);
    chk("first_no_event", 32'(evt_valid), 0);

    // 2. single change
    set_pins(8'h05);
    chk("chg_irq", 32'(irq), 1);
    pop_chk("chg");
    chk("chg_drained", 32'(evt_valid), 0);
    chk("chg_irq_clr", 32'(irq), 0);

    // 3. nine changes without pops -> overflow
    for (int k = 0; k < 9; k++) set_pins(8'h10 + 8'(k));
    chk("ovf_model", 32'(exp_ovf), 1);
    chk("ovf_flag", 32'(evt_ovf), 32'(exp_ovf));
    evt_ovf_clr = 1'b1; @(negedge clk); evt_ovf_clr = 1'b0; @(negedge clk);
    chk("ovf_cleared", 32'(evt_ovf), 0);
    chk("ovf_irq_fifo", 32'(irq), 1);
    for (int k = 0; k < 8; k++) pop_chk("ovf_evt");
    chk("ovf_drained", 32'(evt_valid), 0);
    chk("ovf_irq_off", 32'(irq), 0);

    // 4. responder ignores a read -> timeout
    wait_rd(n_rd + 1, 60);
    no_ack = 1'b1; b0 = n_berr; r0 = n_rd;
    i = 0;
    while (n_berr == b0 && i < 80) begin @(negedge clk); i++; end
    repeat (2) @(negedge clk);
    chk("to_berr_width", 32'(n_berr - b0), 1);
    chk("to_cyc_len", 32'(last_cyc_len), 32'd15);
    chk("to_no_read", 32'(n_rd), 32'(r0));
    chk("to_no_event", 32'(evt_valid), 0);
    no_ack = 1'b0;
    wait_rd(r0 + 1, 60);

    // 5. reset in the middle of a read
    set_pins(8'h33);
    chk("pre_rst_event", 32'(evt_valid), 1);
    ack_delay = 3;
    wait_rd_strobe(60);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", 32'(wb_cyc_o), 0); chk("arst_stb", 32'(wb_stb_o), 0);
    chk("arst_we", 32'(wb_we_o), 0);   chk("arst_fifo", 32'(evt_valid), 0);
    ack_delay = 0; b0 = n_wr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    i = 0;
    while (n_wr == b0 && i < 40) begin @(negedge clk); i++; end
    chk("recfg_write", 32'(n_wr), 32'(b0 + 1));
    chk("recfg_adr", wr_adr, 32'h8);

    // 6. en falls while a delayed read is outstanding
    ack_delay = 3;
    wait_rd_strobe(60);
    en = 1'b0; r0 = n_rd; b0 = n_berr;
    i = 0;
    while (wb_cyc_o && i < 30) begin @(negedge clk); i++; end
    @(negedge clk);
    chk("dis_read_done", 32'(n_rd), 32'(r0 + 1));
    chk("dis_cyc_len", 32'(last_cyc_len), 32'd5);
    chk("dis_no_berr", 32'(n_berr), 32'(b0));
    s0 = stb_rises;
    repeat (40) @(negedge clk);
    chk("dis_no_strobe", 32'(stb_rises), 32'(s0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
